// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoder definitions: descriptor format codes, base opcodes,
// the canonical NOP word and the loader FSM state encoding.
package instr_encoder_pkg;

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_LOAD  = 3'd2;
    localparam logic [2:0] FMT_STORE = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;

    // Same values as the ID-stage decoder's opcode table.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded words; head is valid whenever empty is low.
// Latency: a push is visible at the head on the following cycle.
module instr_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I descriptor encoder and imem loader: encodes accepted descriptors, buffers and writes them
// to consecutive byte addresses. Optional immediate range checking via INSTR_ENC_RANGE_CHK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [2:0]         in_funct3,
    input  logic               in_alt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [WORD_W-1:0]  in_imm,
    input  logic               in_last,
    output logic               imem_we,
    input  logic               imem_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);
    enc_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               push, pop, fifo_full, fifo_empty;
    logic [INSTR_W-1:0] enc_word, raw_word, fifo_head;

    function automatic logic [31:0] encode(input logic [2:0] fmt, input logic [2:0] f3,
                                           input logic alt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [WORD_W-1:0] imm);
        logic [31:0] w;
        w = NOP_INSTR;
        case (fmt)
            FMT_R:     w = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
            FMT_I: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    w = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
                end
            end
            FMT_LOAD:  w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            FMT_STORE: w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            FMT_B:     w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            default:   w = NOP_INSTR;
        endcase
        return w;
    endfunction

    assign raw_word = encode(in_fmt, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm);

    assign in_ready   = (state_q == ST_RUN) && !fifo_full;
    assign push       = in_valid && in_ready;
    assign imem_we    = (state_q == ST_RUN || state_q == ST_DRAIN) && !fifo_empty;
    assign pop        = imem_we && imem_ready;
    assign imem_addr  = addr_q;
    assign imem_wdata = fifo_empty ? '0 : fifo_head;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

`ifdef INSTR_ENC_RANGE_CHK_EN
    logic err_q, err_d;
    logic s12, s13, imm_ok;

    // Upper bits must all be copies of the sign bit for the value to fit.
    assign s12 = (&in_imm[WORD_W-1:11]) | ~(|in_imm[WORD_W-1:11]);
    assign s13 = (&in_imm[WORD_W-1:12]) | ~(|in_imm[WORD_W-1:12]);

    always_comb begin
        imm_ok = 1'b1;
        case (in_fmt)
            FMT_I: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    imm_ok = s12 && (in_imm[11:5] == 7'd0);
                end else begin
                    imm_ok = s12;
                end
            end
            FMT_LOAD, FMT_STORE: imm_ok = s12;
            FMT_B:               imm_ok = s13 && !in_imm[0];
            default:             imm_ok = 1'b1;
        endcase
    end

    assign enc_word = imm_ok ? raw_word : NOP_INSTR;
    assign err      = err_q;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            err_d = 1'b0;
        end else if (push && !imm_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_imm_bits;

    assign unused_imm_bits = ^{in_imm[WORD_W-1:13], in_imm[0]};
    assign enc_word        = raw_word;
    assign err             = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = base_addr;
                end
            end
            ST_RUN:   if (push && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)      state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (pop) begin
            addr_d = addr_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    instr_fifo #(
        .W     (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (enc_word),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and instruction-memory loader, the inverse of the ID-stage decoder. It accepts decoded instruction descriptors (format, funct3, alt bit, register indices, immediate) over a valid/ready stream. It packs each descriptor into a 32-bit instruction word, buffers words in a small FIFO, and writes them to consecutive instruction-memory byte addresses. It sits beside the core on the imem write port and is used for boot-time program loading and self-test.

## Interface
- `INSTR_W`, 32, instruction width
- `WORD_W`, 32, immediate width
- `ADDR_W`, 12, imem byte-address width
- `FIFO_DEPTH`, 4, encoded-word buffer depth (power of two, ≥2)

- `clk` input 1: clock
- `rst_n` input 1: reset, asynchronous, active-low
- `start` input 1: begin a load session (sampled only in IDLE)
- `base_addr` input ADDR_W: first write address, sampled with `start`
- `in_valid` input 1: descriptor valid
- `in_ready` output 1: descriptor accepted when `in_valid && in_ready`
- `in_fmt` input 3: 0=R, 1=I (ALU), 2=LOAD, 3=STORE, 4=B; others invalid
- `in_funct3` input 3: funct3 field
- `in_alt` input 1: funct7[5] (SUB/SRA/SRAI)
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices
- `in_imm` input WORD_W: sign-extended immediate (byte offset for B)
- `in_last` input 1: final descriptor of the session
- `imem_we` output 1: write request
- `imem_ready` input 1: write completes when `imem_we && imem_ready`
- `imem_addr` output ADDR_W: write byte address
- `imem_wdata` output INSTR_W: encoded instruction
- `busy` output 1: state ≠ IDLE
- `done` output 1: one-cycle pulse at session end
- `err` output 1: sticky immediate-range error (see Configuration)

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: `in_ready`=0. On `start`: load address register with `base_addr`, clear `err`, go to RUN.
- RUN: `in_ready` = FIFO not full. There is no pop-through, so a full FIFO deasserts `in_ready` even if a pop occurs that cycle. An accepted descriptor is encoded combinationally and pushed the same cycle. Accepting one with `in_last`=1 goes to DRAIN.
- DRAIN: `in_ready`=0. When the FIFO is empty, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Write port: `imem_we` = (RUN or DRAIN) && FIFO not empty. `imem_wdata` = FIFO head, driven 0 when the FIFO is empty. On each completed write: pop, and the address increments by 4 modulo 2^ADDR_W (wraps silently).
- Encoding, bits [31:0]:
  - R, opcode 0110011: {alt?0100000:0000000, rs2, rs1, f3, rd, opc}
  - I, opcode 0010011: {imm[11:0], rs1, f3, rd, opc}. For f3=001/101, bits [31:25]={0,alt,00000} and [24:20]=imm[4:0].
  - LOAD, opcode 0000011: same layout as I (no shift rule).
  - STORE, opcode 0100011: {imm[11:5], rs2, rs1, f3, imm[4:0], opc}
  - B, opcode 1100011: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}
  - Invalid fmt: NOP 0x00000013.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, FIFO empty, address 0, all outputs 0.
- Latency: a descriptor accepted in cycle N can be written in cycle N+1 at the earliest.
- Throughput: one descriptor per cycle and one write per cycle.
- Simultaneous push and pop is legal when the FIFO is not full.
- `rst_n` low mid-session immediately aborts: FIFO flushed, no further writes, no `done` pulse.

## Configuration
- `INSTR_ENC_RANGE_CHK_EN` defined: immediate range checking is enabled.
  - I and LOAD: `in_imm` must fit signed 12 bits. Shift-I requires imm[11:5]=0.
  - STORE: `in_imm` must fit signed 12 bits.
  - B: `in_imm` must fit signed 13 bits and be even.
  - On violation: the word is replaced by NOP 0x00000013 and `err` is set (sticky until the next `start`).
- Undefined: immediates are silently truncated and `err` is tied to 0.

## Structure
- Shared header/package: format codes, opcode constants (shared with the decoder's opcode definitions), NOP constant, state encoding.
- One sub-module, `instr_fifo`: a synchronous FIFO (push, pop, full, empty, head).
- Encoding is a combinational function inside `instr_encoder`.

## Test plan
- Reset: hold `rst_n` low with random inputs → all outputs 0, `in_ready`=0. Release → stays IDLE.
- Session at `base_addr`=0x100, R x3,x1,x2, alt=0, last → write 0x002081B3 at 0x100, then `done` pulse, then IDLE. Repeat with alt=1 → 0x402081B3.
- STORE f3=010, rs1=1, rs2=2, imm=8 → 0x0020A423. B f3=0, rs1=1, rs2=2, imm=-4 → 0xFE208EE3.
- Backpressure: `imem_ready`=0, offer 5 descriptors, FIFO_DEPTH=4 → 4 accepted, then `in_ready`=0. Release → 5 writes at base, +4, +8, +12, +16 in order.
- Wrap and abort: base 0xFFC, two descriptors → addresses 0xFFC then 0x000. Assert `rst_n` low mid-DRAIN → no further `imem_we`, no `done`.
- With `INSTR_ENC_RANGE_CHK_EN`: I addi, imm=2048 → write 0x00000013, `err`=1. Next `start` clears `err`. Without the macro → write 0x80000013 (truncated), `err`=0.
